// File: rtl/neuron_layer_seq.sv
// Layer sequencer: time-multiplexes one MAC/quantize/ReLU datapath over NUM_NEURONS neurons.
// Optional macro NEURON_SEQ_PERF_EN adds a 32-bit busy-cycle counter output (cycle_cnt).
`timescale 1ns/1ps
module neuron_layer_seq #(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_NEURONS = 4,
  parameter int IN_AW       = 3,
  parameter int N_AW        = 2,
  parameter int W_AW        = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [W_AW-1:0]   w_addr,
  output logic [IN_AW-1:0]  x_addr,
  output logic [N_AW-1:0]   b_addr,
  output logic              mac_en,
  output logic              mac_load,
  input  logic [15:0]       neuron_result,
  output logic              out_valid,
  output logic [N_AW-1:0]   out_idx,
`ifdef NEURON_SEQ_PERF_EN
  output logic [31:0]       cycle_cnt,
`endif
  output logic [15:0]       out_data
);

  generate
    if (NUM_INPUTS < 2) begin : g_bad_inputs
      $error("neuron_layer_seq: NUM_INPUTS must be >= 2");
    end
    if (NUM_NEURONS < 1) begin : g_bad_neurons
      $error("neuron_layer_seq: NUM_NEURONS must be >= 1");
    end
    if ((1 << IN_AW) < NUM_INPUTS) begin : g_bad_in_aw
      $error("neuron_layer_seq: IN_AW too narrow for NUM_INPUTS");
    end
    if (N_AW < 1 || (1 << N_AW) < NUM_NEURONS) begin : g_bad_n_aw
      $error("neuron_layer_seq: N_AW too narrow for NUM_NEURONS");
    end
    if ((1 << W_AW) < NUM_INPUTS * NUM_NEURONS) begin : g_bad_w_aw
      $error("neuron_layer_seq: W_AW too narrow for the weight array");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, RUN, TAIL, WB, DONE} state_t;

  localparam int unsigned I_LAST_INT = NUM_INPUTS - 1;
  localparam int unsigned N_LAST_INT = NUM_NEURONS - 1;
  localparam logic [IN_AW:0]  I_LAST = I_LAST_INT[IN_AW:0];
  localparam logic [IN_AW:0]  I_ONE  = {{IN_AW{1'b0}}, 1'b1};
  localparam logic [N_AW-1:0] N_LAST = N_LAST_INT[N_AW-1:0];

  state_t          state, state_nxt;
  logic [N_AW-1:0] n, n_nxt;
  logic [IN_AW:0]  i, i_nxt;

  // In RUN, i is the input index whose SRAM read is issued this cycle.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' with every target defaulted first, so no latch is inferred.
    state_nxt = state;
    n_nxt     = n;
    i_nxt     = i;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          n_nxt     = '0;
          i_nxt     = '0;
        end
      end
      RUN: begin
        i_nxt = i + 1'b1;
        if (i == I_LAST) state_nxt = TAIL;
      end
      TAIL: state_nxt = WB;
      WB: begin
        if (n == N_LAST) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
          n_nxt     = n + 1'b1;
          i_nxt     = '0;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM/MAC strobes are decoded from the next state so they line up with the state they belong to;
  // host-facing outputs are decoded from the current state and therefore trail it by one cycle.
  always_ff @(posedge clk) begin
    // NOTE: this block holds no memory arrays, so every register takes an explicit synchronous reset.
    if (rst) begin
      state     <= IDLE;
      n         <= '0;
      i         <= '0;
      rd_en     <= 1'b0;
      mac_en    <= 1'b0;
      mac_load  <= 1'b0;
      w_addr    <= '0;
      x_addr    <= '0;
      b_addr    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
      state    <= state_nxt;
      n        <= n_nxt;
      i        <= i_nxt;
      rd_en    <= (state_nxt == RUN);
      mac_en   <= ((state_nxt == RUN) && (i_nxt != '0)) || (state_nxt == TAIL);
      mac_load <= (state_nxt == RUN) && (i_nxt == I_ONE);

      // Neurons are read back to back, so the weight address is one running counter per layer.
      if (state_nxt == RUN) begin
        w_addr <= (state == IDLE) ? '0 : w_addr + 1'b1;
        x_addr <= i_nxt[IN_AW-1:0];
        b_addr <= n_nxt;
      end

      busy      <= (state == RUN) || (state == TAIL) || (state == WB);
      done      <= (state == DONE);
      out_valid <= (state == WB);
      if (state == WB) begin
        out_idx  <= n;
        out_data <= neuron_result;
      end
    end
  end

`ifdef NEURON_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      cycle_cnt <= '0;
    end else if (busy) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_neuron_layer_seq.sv
// Randomized self-checking bench for neuron_layer_seq with an SRAM + MAC environment model.
`timescale 1ns/1ps
module tb_neuron_layer_seq;
  localparam int NI    = 8;
  localparam int NN    = 4;
  localparam int IN_AW = 3;
  localparam int N_AW  = 2;
  localparam int W_AW  = 5;
  localparam int L     = NI + 2;
  localparam int LAYER = NN * L;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             busy, done, rd_en, mac_en, mac_load, out_valid;
  logic [W_AW-1:0]  w_addr;
  logic [IN_AW-1:0] x_addr;
  logic [N_AW-1:0]  b_addr, out_idx;
  logic [15:0]      neuron_result, out_data;
`ifdef NEURON_SEQ_PERF_EN
  logic [31:0]      cycle_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  neuron_layer_seq #(
    .NUM_INPUTS(NI), .NUM_NEURONS(NN), .IN_AW(IN_AW), .N_AW(N_AW), .W_AW(W_AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .rd_en(rd_en),
    .w_addr(w_addr), .x_addr(x_addr), .b_addr(b_addr), .mac_en(mac_en), .mac_load(mac_load),
    .neuron_result(neuron_result), .out_valid(out_valid), .out_idx(out_idx),
`ifdef NEURON_SEQ_PERF_EN
    .cycle_cnt(cycle_cnt),
`endif
    .out_data(out_data)
  );

  // Environment: SRAMs with one-cycle read latency and a MAC feeding a ReLU/saturate stage.
  int w_mem [NN*NI];
  int x_mem [NI];
  int b_mem [NN];
  int w_q = 0, x_q = 0, b_q = 0, acc = 0;

  function automatic logic [15:0] relu_q(input int a);
    logic [15:0] r;
    if (a < 0)          r = '0;
    else if (a > 32767) r = 16'h7fff;
    else                r = a[15:0];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rd_en) begin
      w_q <= w_mem[w_addr];
      x_q <= x_mem[x_addr];
      b_q <= b_mem[b_addr];
    end
  end

  always @(posedge clk) begin
    if (mac_en) acc <= mac_load ? (b_q + w_q * x_q) : (acc + w_q * x_q);
  end

  assign neuron_result = relu_q(acc);

  // Reference: one neuron as a plain dot product plus bias.
  function automatic logic [15:0] ref_out(input int n);
    int s;
    s = b_mem[n];
    for (int j = 0; j < NI; j++) s += w_mem[n*NI + j] * x_mem[j];
    return relu_q(s);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic fill_data(input bit fixed);
    for (int j = 0; j < NI; j++) x_mem[j] = fixed ? (j + 1) : (int'($urandom_range(200)) - 100);
    for (int j = 0; j < NN*NI; j++) w_mem[j] = fixed ? 1 : (int'($urandom_range(200)) - 100);
    for (int j = 0; j < NN; j++) b_mem[j] = fixed ? (j * 10) : (int'($urandom_range(4000)) - 2000);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".busy"},      32'(busy),      0);
    check({tag, ".done"},      32'(done),      0);
    check({tag, ".rd_en"},     32'(rd_en),     0);
    check({tag, ".mac_en"},    32'(mac_en),    0);
    check({tag, ".mac_load"},  32'(mac_load),  0);
    check({tag, ".out_valid"}, 32'(out_valid), 0);
    check({tag, ".out_idx"},   32'(out_idx),   0);
    check({tag, ".out_data"},  32'(out_data),  0);
    check({tag, ".w_addr"},    32'(w_addr),    0);
    check({tag, ".x_addr"},    32'(x_addr),    0);
    check({tag, ".b_addr"},    32'(b_addr),    0);
`ifdef NEURON_SEQ_PERF_EN
    check({tag, ".cycle_cnt"}, cycle_cnt,      0);
`endif
  endtask

  // k counts cycles after the edge that accepted start; expectations follow the layer timetable.
  task automatic check_cycle(input int k, input bit fixed);
    int n, p, idx;
    bit in_l, e_rd, e_mac, e_load, e_busy, e_ov, e_done;
    logic [15:0] e_data;
    n      = k / L;
    p      = k % L;
    in_l   = (k < LAYER);
    e_rd   = in_l && (p < NI);
    e_mac  = in_l && (p >= 1) && (p <= NI);
    e_load = in_l && (p == 1);
    e_busy = (k >= 1) && (k <= LAYER);
    e_ov   = (k >= L) && (k <= LAYER) && (p == 0);
    e_done = (k == LAYER + 1);
    check($sformatf("busy@%0d", k),      32'(busy),      32'(e_busy));
    check($sformatf("done@%0d", k),      32'(done),      32'(e_done));
    check($sformatf("rd_en@%0d", k),     32'(rd_en),     32'(e_rd));
    check($sformatf("mac_en@%0d", k),    32'(mac_en),    32'(e_mac));
    check($sformatf("mac_load@%0d", k),  32'(mac_load),  32'(e_load));
    check($sformatf("out_valid@%0d", k), 32'(out_valid), 32'(e_ov));
    if (e_rd) begin
      check($sformatf("w_addr@%0d", k), 32'(w_addr), 32'(n*NI + p));
      check($sformatf("x_addr@%0d", k), 32'(x_addr), 32'(p));
      check($sformatf("b_addr@%0d", k), 32'(b_addr), 32'(n));
    end
    if (e_ov) begin
      idx    = k / L - 1;
      e_data = fixed ? 16'(36 + 10*idx) : ref_out(idx);
      check($sformatf("out_idx@%0d", k),  32'(out_idx),  32'(idx));
      check($sformatf("out_data@%0d", k), 32'(out_data), 32'(e_data));
    end
`ifdef NEURON_SEQ_PERF_EN
    check($sformatf("cycle_cnt@%0d", k), cycle_cnt,
          (k == 0) ? 0 : ((k <= LAYER + 1) ? 32'(k - 1) : 32'(LAYER)));
`endif
  endtask

  task automatic start_layer();
    @(negedge clk);
    start = 1'b1;
  endtask

  // pulses: extra start pulses sampled while busy (edge t0+5) and in DONE (edge t0+LAYER+1).
  task automatic run_layer(input int last_k, input bit pulses, input bit hold, input bit fixed);
    for (int k = 0; k <= last_k; k++) begin
      @(negedge clk);
      if (k == 0 && !hold) start = 1'b0;
      check_cycle(k, fixed);
      if (pulses) begin
        if (k == 4 || k == LAYER) start = 1'b1;
        else if (k == 5 || k == LAYER + 1) start = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    fill_data(1'b1);
    start_layer();
    run_layer(LAYER + 4, 1'b1, 1'b0, 1'b1);

    fill_data(1'b0);
    start_layer();
    run_layer(LAYER + 4, 1'b0, 1'b0, 1'b0);

    fill_data(1'b0);
    start_layer();
    run_layer(LAYER + 1, 1'b0, 1'b1, 1'b0);
    run_layer(LAYER + 4, 1'b0, 1'b0, 1'b0);

    fill_data(1'b0);
    start_layer();
    run_layer(14, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_zero("abort");
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("post_abort.busy@%0d", c),      32'(busy),      0);
      check($sformatf("post_abort.done@%0d", c),      32'(done),      0);
      check($sformatf("post_abort.out_valid@%0d", c), 32'(out_valid), 0);
    end

    fill_data(1'b0);
    start_layer();
    run_layer(LAYER + 4, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
